// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared FSM state type and default timing constants for reset_sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    ASSERTED = 2'd2
  } state_e;
  localparam int DEF_HOLD_CYCLES   = 8;
  localparam int DEF_FILTER_CYCLES = 3;
endpackage

// File: rtl/req_sync_filter.sv
// req_sync_filter: 2-flop synchronizer plus run-length filter for the external reset request
//   clk      in  : clock, all flops on posedge
//   reset    in  : synchronous active-high reset
//   rst_req  in  : asynchronous request level
//   req_filt out : request level accepted after FILTER_CYCLES consecutive agreeing samples
module req_sync_filter
  import reset_seq_pkg::*;
#(
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_req,
  output logic req_filt
);
  localparam int FW = $clog2(FILTER_CYCLES) + 1;
  logic sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d, flip, done;
  logic [FW-1:0] cnt_q, cnt_d;
  // cnt counts consecutive samples disagreeing with the filtered level; any agreeing sample restarts it
  always_comb begin
    sync1_d = rst_req;
    sync2_d = sync1_q;
    flip    = sync2_q != filt_q;
    done    = flip && (cnt_q == FW'(FILTER_CYCLES - 1));
    cnt_d   = (flip && !done) ? cnt_q + 1'b1 : '0;
    filt_d  = done ? sync2_q : filt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end
  assign req_filt = filt_q;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: filters an external reset request and sequences a held, registered downstream reset
//   clk        in  : clock, all flops on posedge
//   reset      in  : synchronous active-high reset, overrides everything
//   rst_req    in  : asynchronous reset request level
//   rst_out    out : registered downstream reset, high unless in RUN
//   asrt_pulse out : one cycle on RUN->ASSERTED
//   rel_pulse  out : one cycle on HOLD->RUN
//   evt_cnt    out : saturating count of assertions when RST_SEQ_EVT_CNT_EN is defined, else 0
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_req,
  output logic       rst_out,
  output logic       asrt_pulse,
  output logic       rel_pulse,
  output logic [7:0] evt_cnt
);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  state_e state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic rst_out_q, rst_out_d, asrt_q, asrt_d, rel_q, rel_d, req_filt;
  req_sync_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
    .clk      (clk),
    .reset    (reset),
    .rst_req  (rst_req),
    .req_filt (req_filt)
  );
  // hold_cnt only advances in HOLD and leaves at HOLD_CYCLES-1, so it never wraps;
  // every other state parks it at 0 so a re-entered HOLD always runs the full count
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = '0;
    case (state_q)
      HOLD: begin
        if (req_filt) state_d = ASSERTED;
        else if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) state_d = RUN;
        else hold_cnt_d = hold_cnt_q + 1'b1;
      end
      RUN:      state_d = req_filt ? ASSERTED : RUN;
      ASSERTED: state_d = req_filt ? ASSERTED : HOLD;
      default:  state_d = HOLD;
    endcase
    // outputs are decoded from the next state so they switch on the same edge as the state
    rst_out_d = state_d != RUN;
    asrt_d    = (state_q == RUN) && (state_d == ASSERTED);
    rel_d     = (state_q == HOLD) && (state_d == RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      rst_out_q  <= 1'b1;
      asrt_q     <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_out_q  <= rst_out_d;
      asrt_q     <= asrt_d;
      rel_q      <= rel_d;
    end
  end
  assign rst_out    = rst_out_q;
  assign asrt_pulse = asrt_q;
  assign rel_pulse  = rel_q;
`ifdef RST_SEQ_EVT_CNT_EN
  logic [7:0] evt_cnt_q, evt_cnt_d;
  always_comb evt_cnt_d = (asrt_d && evt_cnt_q != 8'hff) ? evt_cnt_q + 8'd1 : evt_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) evt_cnt_q <= '0;
    else evt_cnt_q <= evt_cnt_d;
  end
  assign evt_cnt = evt_cnt_q;
`else
  assign evt_cnt = '0;
`endif
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scoreboard bench for reset_sequencer (HOLD_CYCLES=8, FILTER_CYCLES=3)
module tb_reset_sequencer;
  logic clk = 1'b0, reset = 1'b1, rst_req = 1'b0;
  logic rst_out, asrt_pulse, rel_pulse;
  logic [7:0] evt_cnt;
  int cyc = 0, vectors = 0, miscompares = 0, n_ev = 0;
`ifdef RST_SEQ_EVT_CNT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif
  typedef struct {
    int         cyc;
    bit         rel;
    logic [7:0] evt;
  } exp_t;
  exp_t sbq[$];
  reset_sequencer #(.HOLD_CYCLES(8), .FILTER_CYCLES(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .rst_req    (rst_req),
    .rst_out    (rst_out),
    .asrt_pulse (asrt_pulse),
    .rel_pulse  (rel_pulse),
    .evt_cnt    (evt_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] exp_evt(int n);
    return EVT_EN ? 8'(n > 255 ? 255 : n) : 8'd0;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask
  task automatic push(int c, bit rel, int n);
    exp_t e;
    e.cyc = c;
    e.rel = rel;
    e.evt = exp_evt(n);
    sbq.push_back(e);
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  // Request rises after edge c: sync 2 edges, filter 3 edges, FSM 1 edge -> rst_out at c+6.
  // Fall after edge c+h: req_filt clears at c+h+5, HOLD entered at c+h+6, 8 hold edges -> RUN at c+h+14.
  task automatic event_run(int h);
    int c;
    c = cyc;
    rst_req = 1'b1;
    if (h >= 3) begin
      n_ev++;
      push(c + 6, 1'b0, n_ev);
      push(c + h + 14, 1'b1, n_ev);
    end
    step(h);
    rst_req = 1'b0;
    step(16);
    check("idle_rst_out", rst_out, 0);
    check("sb_drained", sbq.size(), 0);
  endtask
  always @(negedge clk) begin
    if (asrt_pulse === 1'b1 || rel_pulse === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse at cycle %0d: got asrt=%0b rel=%0b, expected no pulse", cyc, asrt_pulse, rel_pulse);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_kind", {asrt_pulse, rel_pulse}, e.rel ? 2'b01 : 2'b10);
        check("pulse_rst_out", rst_out, {31'd0, !e.rel});
        check("pulse_evt_cnt", evt_cnt, e.evt);
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end
  initial begin
    int c0;
    @(negedge clk);
    check("rst_rst_out", rst_out, 1);
    check("rst_asrt", asrt_pulse, 0);
    check("rst_rel", rel_pulse, 0);
    check("rst_evt", evt_cnt, 0);
    step(2);
    reset = 1'b0;
    c0 = cyc;
    push(c0 + 8, 1'b1, 0);
    step(7);
    check("hold_rst_out_7", rst_out, 1);
    step(1);
    check("hold_rst_out_8", rst_out, 0);
    step(3);
    check("sb_after_reset", sbq.size(), 0);
    event_run(10);
    c0 = cyc;
    event_run(2);
    check("short_evt", evt_cnt, exp_evt(n_ev));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rst_req = 1'b1;
    c0 = cyc;
    n_ev = 0;
    // req_filt reaches the FSM at hold_cnt=5, aborting the hold; full 8-edge hold restarts after release
    push(c0 + 24, 1'b1, 0);
    step(7);
    check("abort_rst_out", rst_out, 1);
    step(3);
    rst_req = 1'b0;
    step(16);
    check("abort_done_rst_out", rst_out, 0);
    check("abort_sb_drained", sbq.size(), 0);
    c0 = cyc;
    rst_req = 1'b1;
    n_ev++;
    push(c0 + 6, 1'b0, n_ev);
    step(8);
    check("asserted_rst_out", rst_out, 1);
    reset = 1'b1;
    rst_req = 1'b0;
    step(1);
    reset = 1'b0;
    n_ev = 0;
    check("midrst_rst_out", rst_out, 1);
    check("midrst_evt", evt_cnt, 0);
    check("midrst_asrt", asrt_pulse, 0);
    push(cyc + 8, 1'b1, 0);
    step(7);
    check("midrst_hold", rst_out, 1);
    step(3);
    check("midrst_released", rst_out, 0);
    check("midrst_sb_drained", sbq.size(), 0);
    for (int i = 0; i < 300; i++) event_run(4);
    check("stress_evt", evt_cnt, exp_evt(300));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
